// File: rtl/smc_seq_ctrl.sv
// smc_seq_ctrl -- transistor frame sequencer.
//
// Collects NUM_DEV (6) transistor beats per frame. Each beat is turned into a
// drain current (Id) or transconductance (gm) figure with a square-law model.
// The figure is inserted into a descending sorted list. After the sixth beat,
// three entries are picked: the three largest or the three smallest. They are
// combined into a weighted frame result.
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   a beat is present on mode/W/V_GS/V_DS
//   in_ready   out  1   beat accepted this cycle (COLLECT state only)
//   mode       in   2   bit0: 1=Id 0=gm; bit1: 1=three largest 0=three smallest
//   W          in   3   channel width
//   V_GS       in   3   gate-source voltage
//   V_DS       in   3   drain-source voltage
//   out_valid  out  1   one-cycle pulse, out_n holds a new frame result
//   out_n      out 10   weighted frame result
//
// Handshake: a beat transfers on a rising edge where in_valid=1 and
// in_ready=1. The source holds the beat stable until that edge. in_ready does
// not depend on in_valid.
module smc_seq_ctrl #(
    parameter int VTH     = 1,
    parameter int NUM_DEV = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] mode,
    input  logic [2:0] W,
    input  logic [2:0] V_GS,
    input  logic [2:0] V_DS,
    output logic       out_valid,
    output logic [9:0] out_n
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CALC    = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    localparam logic [2:0] LAST_BEAT = 3'(NUM_DEV - 1);
    localparam logic [9:0] VTH_W     = 10'(VTH);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [1:0] mode_q;
    logic [6:0] list_q   [6];
    logic [6:0] list_nxt [6];
    logic       accept;
    logic       mode_id;
    logic [6:0] beat_res;
    logic [9:0] calc_n;

    assign in_ready = (state == ST_COLLECT);
    assign accept   = in_valid && in_ready;

    // The first beat of a frame is evaluated with the live mode bits, because
    // they are being latched on that same edge.
    assign mode_id = (cnt == 3'd0) ? mode[0] : mode_q[0];

    // Per-beat square-law figure. The 10-bit intermediates cover the worst
    // case over all 3-bit inputs even for VTH=0.
    always_comb begin
        logic [9:0] vov;
        logic [9:0] vds;
        logic [9:0] wv;
        logic [9:0] prod_id;
        logic [9:0] prod_gm;
        vds     = 10'(V_DS);
        wv      = 10'(W);
        vov     = (10'(V_GS) > VTH_W) ? (10'(V_GS) - VTH_W) : 10'd0;
        prod_id = 10'd0;
        prod_gm = 10'd0;
        if (vov > vds) begin
            prod_id = wv * vds * (10'd2 * vov - vds);
            prod_gm = 10'd2 * wv * vds;
        end else begin
            prod_id = wv * vov * vov;
            prod_gm = 10'd2 * wv * vov;
        end
        beat_res = mode_id ? 7'(prod_id / 10'd3) : 7'(prod_gm / 10'd3);
    end

    // Sorted insert, descending. An incoming value equal to existing entries
    // lands after them, so ties keep arrival order. The last entry drops off.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            list_nxt[i] = list_q[i];
        end
        if (list_q[0] < beat_res) begin
            list_nxt[0] = beat_res;
        end
        for (int i = 1; i < 6; i++) begin
            if (list_q[i] >= beat_res) begin
                list_nxt[i] = list_q[i];
            end else if (list_q[i-1] >= beat_res) begin
                list_nxt[i] = beat_res;
            end else begin
                list_nxt[i] = list_q[i-1];
            end
        end
    end

    // Weighted combination of the selected three entries (n0 >= n1 >= n2).
    always_comb begin
        logic [9:0] n0;
        logic [9:0] n1;
        logic [9:0] n2;
        if (mode_q[1]) begin
            n0 = 10'(list_q[0]);
            n1 = 10'(list_q[1]);
            n2 = 10'(list_q[2]);
        end else begin
            n0 = 10'(list_q[3]);
            n1 = 10'(list_q[4]);
            n2 = 10'(list_q[5]);
        end
        if (mode_q[0]) begin
            calc_n = 10'd3 * n0 + 10'd4 * n1 + 10'd5 * n2;
        end else begin
            calc_n = n0 + n1 + n2;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (accept && (cnt == LAST_BEAT)) state_nxt = ST_CALC;
            ST_CALC:    state_nxt = ST_OUT;
            ST_OUT:     state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_COLLECT;
            cnt       <= 3'd0;
            mode_q    <= 2'd0;
            out_n     <= 10'd0;
            out_valid <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                list_q[i] <= 7'd0;
            end
        end else begin
            state <= state_nxt;
            // The pulse is raised on the edge that leaves OUT.
            out_valid <= (state == ST_OUT);
            if (accept) begin
                cnt <= (cnt == LAST_BEAT) ? 3'd0 : cnt + 3'd1;
                if (cnt == 3'd0) begin
                    mode_q <= mode;
                end
            end
            if (state == ST_CALC) begin
                out_n <= calc_n;
            end
            // Clear the list on the way back to COLLECT so no entries of
            // this frame leak into the next one.
            if (state == ST_OUT) begin
                for (int i = 0; i < 6; i++) begin
                    list_q[i] <= 7'd0;
                end
            end else if (accept) begin
                for (int i = 0; i < 6; i++) begin
                    list_q[i] <= list_nxt[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Self-checking bench for smc_seq_ctrl. Inputs are driven and outputs sampled
// on the falling edge. Expected frame results come from a square-law model and
// a plain sort of the six beat values.
module tb_smc_seq_ctrl;

    localparam int VTH = 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [2:0] W;
    logic [2:0] V_GS;
    logic [2:0] V_DS;
    logic       out_valid;
    logic [9:0] out_n;

    always #5 clk = ~clk;

    smc_seq_ctrl #(.VTH(VTH), .NUM_DEV(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .W         (W),
        .V_GS      (V_GS),
        .V_DS      (V_DS),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [1:0] f_mode;
    int         f_w [6];
    int         f_g [6];
    int         f_d [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int beat_model(input bit is_id, input int w, input int g, input int d);
        int vov;
        vov = (g > VTH) ? g - VTH : 0;
        if (vov == 0) return 0;
        if (vov > d) return is_id ? (w * d * (2 * vov - d)) / 3 : (2 * w * d) / 3;
        return is_id ? (w * vov * vov) / 3 : (2 * w * vov) / 3;
    endfunction

    function automatic int frame_model();
        int v [6];
        int t;
        int a, b, c;
        for (int i = 0; i < 6; i++) v[i] = beat_model(f_mode[0], f_w[i], f_g[i], f_d[i]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        if (f_mode[1]) begin a = v[0]; b = v[1]; c = v[2]; end
        else           begin a = v[3]; b = v[4]; c = v[5]; end
        return f_mode[0] ? 3 * a + 4 * b + 5 * c : a + b + c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_beat(input int i, input bit gaps);
        int waited;
        mode     = (i == 0) ? f_mode : 2'($urandom_range(0, 3));
        W        = 3'(f_w[i]);
        V_GS     = 3'(f_g[i]);
        V_DS     = 3'(f_d[i]);
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 10) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic run_frame(input int exp_n, input bit gaps, input bit hold);
        for (int i = 0; i < 6; i++) send_beat(i, gaps && (i < 5));
        if (hold) begin
            in_valid = 1'b1;
            mode     = 2'($urandom_range(0, 3));
            W        = 3'($urandom_range(0, 7));
            V_GS     = 3'($urandom_range(0, 7));
            V_DS     = 3'($urandom_range(0, 7));
        end
        check("calc_ready", {31'd0, in_ready}, 32'd0);
        check("calc_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("out_ready", {31'd0, in_ready}, 32'd0);
        check("early_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("pulse", {31'd0, out_valid}, 32'd1);
        check("out_n", {22'd0, out_n}, 32'(exp_n));
        check("ready_back", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("pulse_end", {31'd0, out_valid}, 32'd0);
        check("out_n_hold", {22'd0, out_n}, 32'(exp_n));
    endtask

    task automatic random_arrays();
        f_mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < 6; i++) begin
            f_w[i] = $urandom_range(0, 7);
            f_g[i] = $urandom_range(0, 7);
            f_d[i] = $urandom_range(0, 7);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_n", {22'd0, out_n}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 2'd0; W = 3'd0; V_GS = 3'd0; V_DS = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        // Triode Id, largest three
        f_mode = 2'b11;
        for (int i = 0; i < 6; i++) begin f_w[i] = 1; f_g[i] = 3; f_d[i] = 1; end
        run_frame(12, 1'b0, 1'b0);

        // Saturation gm, largest three
        f_mode = 2'b10;
        for (int i = 0; i < 6; i++) begin f_w[i] = 7; f_g[i] = 7; f_d[i] = 7; end
        run_frame(84, 1'b0, 1'b0);

        // gm, smallest three
        f_mode = 2'b00;
        for (int i = 0; i < 6; i++) begin f_w[i] = i + 1; f_g[i] = 2; f_d[i] = 3; end
        run_frame(3, 1'b0, 1'b0);

        // Cutoff beats (V_GS=0/1) mixed in
        f_mode = 2'b11;
        for (int i = 0; i < 6; i++) begin f_w[i] = 7; f_d[i] = 2; end
        f_g[0] = 0; f_g[1] = 1; f_g[2] = 5; f_g[3] = 1; f_g[4] = 0; f_g[5] = 7;
        run_frame(250, 1'b0, 1'b1);

        // Reset after three beats, with a beat offered during reset
        random_arrays();
        for (int i = 0; i < 3; i++) send_beat(i, 1'b0);
        rst = 1'b1; in_valid = 1'b1; mode = 2'b11; W = 3'd7; V_GS = 3'd7; V_DS = 3'd7;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check_reset_outputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_pulse", {31'd0, out_valid}, 32'd0);
        end
        random_arrays();
        run_frame(frame_model(), 1'b1, 1'b0);

        // Reset while in CALC
        random_arrays();
        for (int i = 0; i < 6; i++) send_beat(i, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("calc_abort_no_pulse", {31'd0, out_valid}, 32'd0);
        end

        // Randomized back-to-back frames with gaps and held in_valid
        for (int f = 0; f < 16; f++) begin
            random_arrays();
            run_frame(frame_model(), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
